// File: rtl/and_test_pkg.sv
// Shared types and constants for the exhaustive two-gate checker.
// The gate DUT takes a 4-bit vector and returns a 2-bit response.
package and_test_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int RSP_W       = 2;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [RSP_W-1:0] rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/and_test_ref.sv
// Golden response for the gate DUT: bit 0 is an AND of in[1:0],
// bit 1 is an OR of in[3:2].
module and_test_ref
    import and_test_pkg::*;
(
    input  vec_t vec,
    output rsp_t exp_rsp
);

    assign exp_rsp = {vec[2] | vec[3], vec[0] & vec[1]};

endmodule

// File: rtl/and_test_checker.sv
// Walks all 16 input vectors through the gate DUT, waits SETTLE_CYCLES
// per vector, and records error count and first failing vector.
module and_test_checker
    import and_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] dut_in,
    input  logic [1:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam vec_t       LAST_VEC    = vec_t'(NUM_VECTORS - 1);
    localparam logic [4:0] ERR_MAX     = 5'(NUM_VECTORS);

    state_t     state;
    state_t     state_next;
    vec_t       vec;
    logic [3:0] settle_cnt;
    rsp_t       exp_rsp;
    logic       mismatch;

    and_test_ref u_ref (
        .vec     (vec),
        .exp_rsp (exp_rsp)
    );

    assign dut_in   = vec;
    assign mismatch = (state == CHECK) && (dut_out != exp_rsp);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next defaults to the current state so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = SETTLE;
            end
            SETTLE: begin
                if (abort)                          state_next = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_next = CHECK;
            end
            CHECK: begin
                if (abort)                 state_next = IDLE;
                else if (vec == LAST_VEC)  state_next = DONE;
                else                       state_next = SETTLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
    end

    // Counter runs only while settling; any other state parks it at zero
    // so each new vector starts a fresh settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec              <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        vec  <= '0;
                        pass <= 1'b0;
                    end
                end
                CHECK: begin
                    // The comparison is kept even when the run is aborted here.
                    if (mismatch) begin
                        if (err_count < ERR_MAX) err_count <= err_count + 5'd1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (abort) begin
                        vec  <= '0;
                        pass <= 1'b0;
                    end else if (vec != LAST_VEC) begin
                        vec <= vec + vec_t'(1);
                    end else begin
                        // pass becomes visible alongside the done pulse.
                        pass <= (err_count == '0) && !mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and_test_checker.sv
// Directed bench for and_test_checker: two instances (SETTLE_CYCLES 1 and 3)
// driven by a gate model with selectable faults.
module tb_and_test_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   fault_mode = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [3:0] dut_in1;
    logic [1:0] dut_out1;
    logic       busy1, done1, pass1, ffval1;
    logic [4:0] err1;
    logic [3:0] ffv1;

    logic       start3 = 1'b0, abort3 = 1'b0;
    logic [3:0] dut_in3;
    logic [1:0] dut_out3;
    logic       busy3, done3, pass3, ffval3;
    logic [4:0] err3;
    logic [3:0] ffv3;

    always #5 clk = ~clk;

    // Gate under test: 0 correct, 1 out[1] stuck 0, 2 out[0] stuck 1,
    // 3 out[0] inverted on vector 9 only.
    function automatic logic [1:0] gate_model(input logic [3:0] v, input int mode);
        logic [1:0] r;
        r = {v[2] | v[3], v[0] & v[1]};
        case (mode)
            1: r[1] = 1'b0;
            2: r[0] = 1'b1;
            3: if (v == 4'd9) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    assign dut_out1 = gate_model(dut_in1, fault_mode);
    assign dut_out3 = gate_model(dut_in3, fault_mode);

    and_test_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start1),
        .abort            (abort1),
        .dut_in           (dut_in1),
        .dut_out          (dut_out1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .err_count        (err1),
        .first_fail_vec   (ffv1),
        .first_fail_valid (ffval1)
    );

    and_test_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start3),
        .abort            (abort3),
        .dut_in           (dut_in3),
        .dut_out          (dut_out3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_count        (err3),
        .first_fail_vec   (ffv3),
        .first_fail_valid (ffval3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    // Counts negedges until done is seen; -1 if the bound expires.
    task automatic wait_done(input bit use3, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((use3 ? done3 : done1) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int pulses;
        int found;

        #1 rst_n = 1'b0;
        #1;
        check("reset_busy",   32'(busy1),   32'h0);
        check("reset_done",   32'(done1),   32'h0);
        check("reset_dut_in", 32'(dut_in1), 32'h0);
        check("reset_err",    32'(err1),    32'h0);
        check("reset_pass",   32'(pass1),   32'h0);
        check("reset_ffval",  32'(ffval1),  32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Correct gate: clean pass after 32 cycles.
        fault_mode = 0;
        pulse_start1();
        check("good_busy_after_start", 32'(busy1), 32'h1);
        check("good_dut_in_first", 32'(dut_in1), 32'h0);
        wait_done(1'b0, 200, cycles);
        check("good_latency", 32'(cycles), 32'd32);
        check("good_pass",    32'(pass1),  32'h1);
        check("good_err",     32'(err1),   32'h0);
        check("good_ffval",   32'(ffval1), 32'h0);
        @(negedge clk);
        check("good_done_one_cycle", 32'(done1), 32'h0);
        check("good_busy_idle",      32'(busy1), 32'h0);
        check("good_pass_holds",     32'(pass1), 32'h1);

        // out[1] stuck at 0: vectors 4..15 fail.
        fault_mode = 1;
        pulse_start1();
        check("s1_pass_cleared_on_start", 32'(pass1), 32'h0);
        wait_done(1'b0, 200, cycles);
        check("s1_latency", 32'(cycles), 32'd32);
        check("s1_err",     32'(err1),   32'd12);
        check("s1_ffv",     32'(ffv1),   32'h4);
        check("s1_ffval",   32'(ffval1), 32'h1);
        check("s1_pass",    32'(pass1),  32'h0);

        // out[0] stuck at 1: every vector except 3,7,11,15 fails.
        fault_mode = 2;
        pulse_start1();
        wait_done(1'b0, 200, cycles);
        check("s0_err",   32'(err1),   32'd12);
        check("s0_ffv",   32'(ffv1),   32'h0);
        check("s0_ffval", 32'(ffval1), 32'h1);
        check("s0_pass",  32'(pass1),  32'h0);

        // Single failure on the last-but-six vector.
        fault_mode = 3;
        pulse_start1();
        wait_done(1'b0, 200, cycles);
        check("one_err",  32'(err1),  32'd1);
        check("one_ffv",  32'(ffv1),  32'h9);
        check("one_pass", 32'(pass1), 32'h0);
        repeat (5) @(negedge clk);
        check("one_err_holds", 32'(err1), 32'd1);
        check("one_ffv_holds", 32'(ffv1), 32'h9);

        // Abort during the CHECK cycle of vector 7 with out[1] stuck at 0.
        fault_mode = 1;
        pulse_start1();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (dut_in1 == 4'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_vec7", 32'(found), 32'h1);
        @(negedge clk) abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        check("abort_busy",   32'(busy1),   32'h0);
        check("abort_dut_in", 32'(dut_in1), 32'h0);
        check("abort_pass",   32'(pass1),   32'h0);
        check("abort_err",    32'(err1),    32'd4);
        check("abort_ffv",    32'(ffv1),    32'h4);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // start+abort together in IDLE, then start re-pulsed mid-run.
        fault_mode = 0;
        @(negedge clk) begin start1 = 1'b1; abort1 = 1'b1; end
        @(negedge clk) begin start1 = 1'b0; abort1 = 1'b0; end
        check("start_wins_busy", 32'(busy1), 32'h1);
        repeat (9) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done(1'b0, 200, cycles);
        check("restart_ignored_latency", 32'(cycles + 10), 32'd32);
        check("restart_ignored_pass",    32'(pass1),       32'h1);

        // SETTLE_CYCLES=3 instance: 16*(3+1) cycles.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        check("s3_busy", 32'(busy3), 32'h1);
        wait_done(1'b1, 300, cycles);
        check("s3_latency", 32'(cycles), 32'd64);
        check("s3_pass",    32'(pass3),  32'h1);
        check("s3_err",     32'(err3),   32'h0);

        // Asynchronous reset mid-run, away from any clock edge.
        fault_mode = 1;
        pulse_start1();
        repeat (10) @(negedge clk);
        check("prereset_err", 32'(err1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy1),   32'h0);
        check("arst_done",   32'(done1),   32'h0);
        check("arst_dut_in", 32'(dut_in1), 32'h0);
        check("arst_err",    32'(err1),    32'h0);
        check("arst_ffv",    32'(ffv1),    32'h0);
        check("arst_ffval",  32'(ffval1),  32'h0);
        check("arst_pass",   32'(pass1),   32'h0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) pulses++;
        end
        check("arst_no_done", 32'(pulses), 32'd0);
        fault_mode = 0;
        pulse_start1();
        wait_done(1'b0, 200, cycles);
        check("post_reset_latency", 32'(cycles), 32'd32);
        check("post_reset_pass",    32'(pass1),  32'h1);
        check("post_reset_err",     32'(err1),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/and_test_checker.md
AND_TEST_CHECKER -- requirements
Module: and_test_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, DUT settle cycles per vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  run request, sampled only in IDLE.
REQ-005 abort  input  1  cancel a run in progress.
REQ-006 dut_in  output  4  stimulus vector driven to the gate DUT.
REQ-007 dut_out  input  2  DUT response; expected [0]=in[0]&in[1], [1]=in[2]|in[3].
REQ-008 busy  output  1  high while a run is in progress (SETTLE or CHECK).
REQ-009 done  output  1  one-cycle pulse when a run completes.
REQ-010 pass  output  1  high when the last completed run had zero mismatches.
REQ-011 err_count  output  5  number of mismatching vectors in the current or last run, 0..16.
REQ-012 first_fail_vec  output  4  first mismatching vector of the run.
REQ-013 first_fail_valid  output  1  first_fail_vec holds a valid value.

Function
REQ-014 FSM states: IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE to SETTLE: start=1 at a clock edge; at the same edge, vec, err_count, first_fail_valid and pass clear to 0, and the settle counter loads 0.
REQ-016 dut_in: always equals the internal vec register.
REQ-017 SETTLE: lasts exactly SETTLE_CYCLES cycles, then moves to CHECK.
REQ-018 CHECK, one cycle:
- Compares dut_out with the expected value for vec; a mismatch on either bit counts as one error.
- Increments err_count on a mismatch.
- On the first mismatch only, loads first_fail_vec=vec and sets first_fail_valid=1.
REQ-019 CHECK exit: vec<15 -> vec increments and state returns to SETTLE; vec=15 -> DONE, with vec held at 15.
REQ-020 DONE, one cycle:
- done=1.
- pass=1 if err_count=0, otherwise pass=0.
- Next state is IDLE.
REQ-021 Latency: done is high in the cycle that begins 16*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
REQ-022 start is ignored in SETTLE, CHECK and DONE; a new run needs a start sampled in IDLE.
REQ-023 abort=1 in SETTLE or CHECK:
- Next state is IDLE.
- vec clears to 0; pass=0.
- done is not pulsed.
- err_count and first_fail fields hold their current values.
- The CHECK-cycle comparison is still recorded.
REQ-024 abort is ignored in IDLE and DONE.
REQ-025 abort and start both high in IDLE: start wins.
REQ-026 Result outputs (pass, err_count, first_fail_vec, first_fail_valid) hold until the next accepted start.
REQ-027 err_count is 5 bits and never wraps; its maximum is 16.

Reset
REQ-028 rst_n low immediately, without waiting for a clock edge:
- forces state IDLE;
- forces vec, dut_in, busy, done, pass, err_count, first_fail_vec and first_fail_valid to 0.
REQ-029 Reset mid-run discards the run; no done pulse is issued afterwards.
REQ-030 Reset deassertion is used directly with no internal synchronizer; integration guarantees timing.

Structure
REQ-031 Package and_test_pkg SHALL hold:
- the FSM state enum;
- NUM_VECTORS=16;
- the vector and response widths (4 and 2).
REQ-032 Golden expected-response logic SHALL be a separate combinational sub-module, and_test_ref, instantiated once.
REQ-033 All sequential logic SHALL live in and_test_checker.

Verification
REQ-034 Correct DUT model, SETTLE_CYCLES=1: one-cycle start -> busy=1 next cycle; done after 32 cycles; pass=1, err_count=0, first_fail_valid=0.
REQ-035 dut_out[1] stuck at 0 -> err_count=12, first_fail_vec=4'h4, first_fail_valid=1, pass=0.
REQ-036 dut_out[0] stuck at 1 -> err_count=12, first_fail_vec=4'h0, pass=0.
REQ-037 Abort while vec=7 -> IDLE next cycle; busy=0, dut_in=0, pass=0; no done pulse.
REQ-038 start re-pulsed mid-run -> ignored, done still at cycle 32; then SETTLE_CYCLES=3 run -> done after 64 cycles.
REQ-039 rst_n low mid-run, no clock edge -> all outputs 0 immediately; later start -> clean full run.
